// File: rtl/noc_pkg.sv
// Shared types and defaults for the NoC output port: flit-type encoding,
// port FSM states and default parameter values.
package noc_pkg;

  localparam int DEF_NUM_IN    = 5;
  localparam int DEF_FLIT_W    = 16;
  localparam int DEF_BUF_DEPTH = 4;

  localparam logic [1:0] FLIT_TYPE_SINGLE = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TYPE_BODY   = 2'b10;
  localparam logic [1:0] FLIT_TYPE_TAIL   = 2'b11;

  typedef enum logic [1:0] {
    FT_SINGLE = FLIT_TYPE_SINGLE,
    FT_HEAD   = FLIT_TYPE_HEAD,
    FT_BODY   = FLIT_TYPE_BODY,
    FT_TAIL   = FLIT_TYPE_TAIL
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } port_state_e;

  // A single or tail flit closes whatever packet owns the port.
  function automatic logic ends_packet(input flit_type_e t);
    return (t == FT_SINGLE) || (t == FT_TAIL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_winner wins.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  last_winner,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  winner
);

  // Walk distances from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    grant  = '0;
    winner = '0;
    for (int i = NUM_IN; i >= 1; i--) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (req[k] && ((int'(last_winner) + i == k) ||
                       (int'(last_winner) + i == k + NUM_IN))) begin
          grant    = '0;
          grant[k] = 1'b1;
          winner   = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/noc_out_port.sv
// NoC router output port: wormhole packet locking, round-robin input selection,
// credit-based flow control toward the downstream buffer, registered flit output.
module noc_out_port
  import noc_pkg::*;
#(
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int FLIT_W    = DEF_FLIT_W,
  parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req_i,
  input  logic [NUM_IN*FLIT_W-1:0] flit_i,
  output logic [NUM_IN-1:0]        grant_o,
  output logic                     valid_o,
  output logic [FLIT_W-1:0]        flit_o,
  input  logic                     incr_i,
  output logic [3:0]               credits_o,
  output logic                     locked_o,
  output logic                     err_o
);

  localparam int         IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [3:0] FULL  = 4'(BUF_DEPTH);

  // Handshake: req_i[k] means flit k is valid; grant_o[k] (combinational, same
  // cycle) means it is consumed. Downstream needs no ready: each grant spends a
  // credit and each incr_i pulse returns one, so valid_o is never refused.

  port_state_e       state, state_nxt;
  logic [IDX_W-1:0]  owner, owner_nxt;
  logic [IDX_W-1:0]  last_winner, last_nxt;
  logic [NUM_IN-1:0] arb_grant, owner_mask;
  logic [IDX_W-1:0]  arb_winner;
  logic              any_grant;
  logic [FLIT_W-1:0] sel_flit;
  flit_type_e        sel_type;
  logic [3:0]        credits, credits_nxt;
  logic              err_nxt;

  rr_arbiter #(.NUM_IN(NUM_IN), .IDX_W(IDX_W)) u_arb (
    .req         (req_i),
    .last_winner (last_winner),
    .grant       (arb_grant),
    .winner      (arb_winner)
  );

  always_comb begin
    owner_mask = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (owner == IDX_W'(k)) owner_mask[k] = 1'b1;
    end
  end

  always_comb begin
    grant_o = '0;
    if (!rst && (credits != 4'd0)) begin
      grant_o = (state == ST_IDLE) ? arb_grant : (owner_mask & req_i);
    end
  end

  assign any_grant = |grant_o;

  always_comb begin
    sel_flit = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant_o[k]) sel_flit = flit_i[k*FLIT_W +: FLIT_W];
    end
  end

  assign sel_type = flit_type_e'(sel_flit[FLIT_W-1 -: 2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last_winner <= IDX_W'(NUM_IN - 1);
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_winner <= last_nxt;
    end
  end

  // Only IDLE grants move the round-robin pointer; a packet keeps it parked on its owner.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_winner;
    if (any_grant) begin
      case (state)
        ST_IDLE: begin
          last_nxt = arb_winner;
          if (sel_type == FT_HEAD) begin
            state_nxt = ST_LOCKED;
            owner_nxt = arb_winner;
          end
        end
        ST_LOCKED: begin
          if (ends_packet(sel_type)) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    credits_nxt = credits;
    err_nxt     = err_o;
    case ({any_grant, incr_i})
      2'b10: credits_nxt = credits - 4'd1;
      2'b01: begin
        if (credits == FULL) err_nxt = 1'b1;
        else                 credits_nxt = credits + 4'd1;
      end
      default: credits_nxt = credits;
    endcase
    if (any_grant && (state == ST_IDLE) &&
        ((sel_type == FT_BODY) || (sel_type == FT_TAIL))) begin
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= FULL;
      err_o   <= 1'b0;
      valid_o <= 1'b0;
      flit_o  <= '0;
    end else begin
      credits <= credits_nxt;
      err_o   <= err_nxt;
      valid_o <= any_grant;
      if (any_grant) flit_o <= sel_flit;
    end
  end

  assign credits_o = credits;
  assign locked_o  = (state == ST_LOCKED);

endmodule

// File: tb/tb_noc_out_port.sv
// Self-checking bench for noc_out_port: directed scenarios plus random traffic
// against a packet-level reference model with a flit scoreboard.
module tb_noc_out_port;
  import noc_pkg::*;

  localparam int NUM_IN    = 5;
  localparam int FLIT_W    = 16;
  localparam int BUF_DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_IN-1:0]        req_i = '0;
  logic [NUM_IN*FLIT_W-1:0] flit_i = '0;
  logic [NUM_IN-1:0]        grant_o;
  logic                     valid_o;
  logic [FLIT_W-1:0]        flit_o;
  logic                     incr_i = 1'b0;
  logic [3:0]               credits_o;
  logic                     locked_o;
  logic                     err_o;

  noc_out_port #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .flit_i    (flit_i),
    .grant_o   (grant_o),
    .valid_o   (valid_o),
    .flit_o    (flit_o),
    .incr_i    (incr_i),
    .credits_o (credits_o),
    .locked_o  (locked_o),
    .err_o     (err_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int                m_credits;
  bit                m_locked;
  int                m_owner;
  int                m_last;
  bit                m_err;
  bit                exp_valid;
  logic [FLIT_W-1:0] exp_hold;
  logic [FLIT_W-1:0] exp_q[$];

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t);
    logic [13:0] p;
    p = 14'($urandom);
    return {t, p};
  endfunction

  function automatic logic [FLIT_W-1:0] flit_of(input int k);
    return flit_i[k*FLIT_W +: FLIT_W];
  endfunction

  // Which input the port should serve this cycle, or -1.
  function automatic int model_pick();
    if (m_credits == 0) return -1;
    if (m_locked) return req_i[m_owner] ? m_owner : -1;
    for (int i = 1; i <= NUM_IN; i++) begin
      if (req_i[(m_last + i) % NUM_IN]) return (m_last + i) % NUM_IN;
    end
    return -1;
  endfunction

  function automatic logic [NUM_IN-1:0] onehot(input int w);
    logic [NUM_IN-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_credits = BUF_DEPTH;
    m_locked  = 1'b0;
    m_owner   = 0;
    m_last    = NUM_IN - 1;
    m_err     = 1'b0;
    exp_valid = 1'b0;
    exp_hold  = '0;
    exp_q.delete();
  endtask

  // Commit the current cycle into the model, then step to just after the clock edge.
  task automatic advance();
    int w;
    logic [FLIT_W-1:0] f;
    logic [1:0] t;
    w = model_pick();
    if (w >= 0) begin
      f = flit_of(w);
      t = f[FLIT_W-1 -: 2];
      exp_q.push_back(f);
      if (!m_locked) begin
        m_last = w;
        if (t == FLIT_TYPE_HEAD) begin
          m_locked = 1'b1;
          m_owner  = w;
        end
        if (t == FLIT_TYPE_BODY || t == FLIT_TYPE_TAIL) m_err = 1'b1;
      end else if (t == FLIT_TYPE_TAIL || t == FLIT_TYPE_SINGLE) begin
        m_locked = 1'b0;
      end
      if (!incr_i) m_credits--;
    end else if (incr_i) begin
      if (m_credits == BUF_DEPTH) m_err = 1'b1;
      else m_credits++;
    end
    exp_valid = (w >= 0);
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point and retire the scoreboard entry due this cycle.
  task automatic sample();
    @(negedge clk);
    if (exp_valid && exp_q.size() > 0) exp_hold = exp_q.pop_front();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst    = 1'b1;
    req_i  = '0;
    incr_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_singles(input logic [NUM_IN-1:0] r);
    req_i = r;
    for (int k = 0; k < NUM_IN; k++) flit_i[k*FLIT_W +: FLIT_W] = mk(FLIT_TYPE_SINGLE);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    drive_singles('1);
    @(negedge clk);
    n_checks++; if (grant_o !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant_o); end
    n_checks++; if (credits_o !== 4'(BUF_DEPTH)) begin n_fail++; $display("FAIL reset_credits: got %0d want %0d", credits_o, BUF_DEPTH); end
    n_checks++; if (valid_o !== 1'b0 || flit_o !== '0) begin n_fail++; $display("FAIL reset_out: got valid=%b flit=%h want 0/0", valid_o, flit_o); end
    n_checks++; if (locked_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got locked=%b err=%b want 0/0", locked_o, err_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_i = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive_singles(5'b10001);
      incr_i = (model_pick() >= 0);
      sample();
      n_checks++; if (grant_o !== onehot((c % 2 == 0) ? 0 : 4)) begin n_fail++; $display("FAIL rr_grant c=%0d: got %b want %b", c, grant_o, onehot((c % 2 == 0) ? 0 : 4)); end
      n_checks++; if (valid_o !== exp_valid) begin n_fail++; $display("FAIL rr_valid c=%0d: got %b want %b", c, valid_o, exp_valid); end
      n_checks++; if (flit_o !== exp_hold) begin n_fail++; $display("FAIL rr_flit c=%0d: got %h want %h", c, flit_o, exp_hold); end
      n_checks++; if (credits_o !== 4'(m_credits)) begin n_fail++; $display("FAIL rr_credits c=%0d: got %0d want %0d", c, credits_o, m_credits); end
      advance();
    end
  endtask

  task automatic test_packet_lock();
    logic [1:0] types[4];
    types = '{FLIT_TYPE_HEAD, FLIT_TYPE_BODY, FLIT_TYPE_BODY, FLIT_TYPE_TAIL};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_i = (c < 4) ? 5'b00110 : 5'b00100;
      flit_i[2*FLIT_W +: FLIT_W] = mk(FLIT_TYPE_SINGLE);
      flit_i[1*FLIT_W +: FLIT_W] = mk((c < 4) ? types[c] : FLIT_TYPE_SINGLE);
      incr_i = (model_pick() >= 0);
      sample();
      n_checks++; if (grant_o !== ((c < 4) ? 5'b00010 : 5'b00100)) begin n_fail++; $display("FAIL lock_grant c=%0d: got %b want %b", c, grant_o, (c < 4) ? 5'b00010 : 5'b00100); end
      n_checks++; if (grant_o !== onehot(model_pick())) begin n_fail++; $display("FAIL lock_model_grant c=%0d: got %b want %b", c, grant_o, onehot(model_pick())); end
      n_checks++; if (locked_o !== ((c >= 1) && (c <= 3))) begin n_fail++; $display("FAIL lock_locked c=%0d: got %b want %b", c, locked_o, (c >= 1) && (c <= 3)); end
      n_checks++; if (valid_o !== exp_valid || flit_o !== exp_hold) begin n_fail++; $display("FAIL lock_out c=%0d: got %b/%h want %b/%h", c, valid_o, flit_o, exp_valid, exp_hold); end
      n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL lock_err c=%0d: got %b want 0", c, err_o); end
      advance();
    end
  endtask

  task automatic test_credit_exhaust();
    int n_gr;
    do_reset();
    incr_i = 1'b0;
    n_gr = 0;
    for (int c = 0; c < 8; c++) begin
      drive_singles(5'b00001);
      sample();
      if (grant_o != '0) n_gr++;
      n_checks++; if (grant_o !== onehot(model_pick())) begin n_fail++; $display("FAIL exh_grant c=%0d: got %b want %b", c, grant_o, onehot(model_pick())); end
      n_checks++; if (credits_o !== 4'(m_credits)) begin n_fail++; $display("FAIL exh_credits c=%0d: got %0d want %0d", c, credits_o, m_credits); end
      advance();
    end
    n_checks++; if (n_gr != BUF_DEPTH) begin n_fail++; $display("FAIL exh_count: got %0d grants want %0d", n_gr, BUF_DEPTH); end
    n_checks++; if (credits_o !== 4'd0) begin n_fail++; $display("FAIL exh_zero: got %0d want 0", credits_o); end
    n_gr = 0;
    for (int c = 0; c < 5; c++) begin
      drive_singles(5'b00001);
      incr_i = (c == 0);
      sample();
      if (grant_o != '0) n_gr++;
      n_checks++; if (grant_o !== onehot(model_pick())) begin n_fail++; $display("FAIL exh2_grant c=%0d: got %b want %b", c, grant_o, onehot(model_pick())); end
      advance();
    end
    incr_i = 1'b0;
    n_checks++; if (n_gr != 1) begin n_fail++; $display("FAIL exh_refill: got %0d grants want 1", n_gr); end
  endtask

  task automatic test_credit_edge();
    req_i  = '0;
    incr_i = 1'b1;
    sample();
    advance();
    drive_singles(5'b00001);
    incr_i = 1'b1;
    sample();
    n_checks++; if (credits_o !== 4'd1 || grant_o !== 5'b00001) begin n_fail++; $display("FAIL edge_pre: got credits=%0d grant=%b want 1/00001", credits_o, grant_o); end
    advance();
    drive_singles(5'b00001);
    incr_i = 1'b0;
    sample();
    n_checks++; if (credits_o !== 4'd1) begin n_fail++; $display("FAIL edge_hold: got %0d want 1", credits_o); end
    n_checks++; if (grant_o !== 5'b00001) begin n_fail++; $display("FAIL edge_regrant: got %b want 00001", grant_o); end
    n_checks++; if (valid_o !== 1'b1 || flit_o !== exp_hold) begin n_fail++; $display("FAIL edge_out: got %b/%h want 1/%h", valid_o, flit_o, exp_hold); end
    advance();
    sample();
    n_checks++; if (credits_o !== 4'd0 || grant_o !== '0) begin n_fail++; $display("FAIL edge_drain: got credits=%0d grant=%b want 0/0", credits_o, grant_o); end
    advance();
  endtask

  task automatic test_overflow();
    do_reset();
    incr_i = 1'b1;
    sample();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got err=%b want 0", err_o); end
    advance();
    incr_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      n_checks++; if (err_o !== 1'b1 || credits_o !== 4'(BUF_DEPTH)) begin n_fail++; $display("FAIL ovf_sticky c=%0d: got err=%b credits=%0d want 1/%0d", c, err_o, credits_o, BUF_DEPTH); end
      advance();
    end
    do_reset();
    sample();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got err=%b want 0", err_o); end
    advance();
  endtask

  task automatic test_orphan_body();
    do_reset();
    req_i = 5'b00100;
    flit_i[2*FLIT_W +: FLIT_W] = mk(FLIT_TYPE_BODY);
    sample();
    n_checks++; if (grant_o !== 5'b00100) begin n_fail++; $display("FAIL orphan_grant: got %b want 00100", grant_o); end
    advance();
    req_i = '0;
    sample();
    n_checks++; if (err_o !== 1'b1 || locked_o !== 1'b0) begin n_fail++; $display("FAIL orphan_flags: got err=%b locked=%b want 1/0", err_o, locked_o); end
    n_checks++; if (valid_o !== 1'b1 || flit_o !== exp_hold) begin n_fail++; $display("FAIL orphan_out: got %b/%h want 1/%h", valid_o, flit_o, exp_hold); end
    advance();
  endtask

  task automatic test_mid_reset();
    do_reset();
    incr_i = 1'b0;
    req_i = 5'b01000;
    flit_i[3*FLIT_W +: FLIT_W] = mk(FLIT_TYPE_HEAD);
    sample();
    advance();
    flit_i[3*FLIT_W +: FLIT_W] = mk(FLIT_TYPE_BODY);
    sample();
    n_checks++; if (locked_o !== 1'b1 || credits_o !== 4'(BUF_DEPTH - 1)) begin n_fail++; $display("FAIL mid_pre: got locked=%b credits=%0d want 1/%0d", locked_o, credits_o, BUF_DEPTH - 1); end
    advance();
    rst = 1'b1;
    model_reset();
    drive_singles('1);
    #1;
    n_checks++; if (locked_o !== 1'b0 || credits_o !== 4'(BUF_DEPTH)) begin n_fail++; $display("FAIL mid_async: got locked=%b credits=%0d want 0/%0d", locked_o, credits_o, BUF_DEPTH); end
    n_checks++; if (valid_o !== 1'b0 || grant_o !== '0) begin n_fail++; $display("FAIL mid_quiet: got valid=%b grant=%b want 0/0", valid_o, grant_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    incr_i = 1'b1;
    sample();
    n_checks++; if (grant_o !== 5'b00001) begin n_fail++; $display("FAIL mid_prio: got %b want 00001", grant_o); end
    advance();
    incr_i = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] t;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_i = NUM_IN'($urandom_range(0, (1 << NUM_IN) - 1));
      for (int k = 0; k < NUM_IN; k++) begin
        t = 2'($urandom_range(0, 3));
        flit_i[k*FLIT_W +: FLIT_W] = mk(t);
      end
      incr_i = ($urandom_range(0, 99) < 45);
      sample();
      n_checks++; if (grant_o !== onehot(model_pick())) begin n_fail++; $display("FAIL rnd_grant c=%0d: got %b want %b", c, grant_o, onehot(model_pick())); end
      n_checks++; if (valid_o !== exp_valid || flit_o !== exp_hold) begin n_fail++; $display("FAIL rnd_out c=%0d: got %b/%h want %b/%h", c, valid_o, flit_o, exp_valid, exp_hold); end
      n_checks++; if (credits_o !== 4'(m_credits)) begin n_fail++; $display("FAIL rnd_credits c=%0d: got %0d want %0d", c, credits_o, m_credits); end
      n_checks++; if (locked_o !== m_locked || err_o !== m_err) begin n_fail++; $display("FAIL rnd_flags c=%0d: got locked=%b err=%b want %b/%b", c, locked_o, err_o, m_locked, m_err); end
      advance();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_credit_exhaust();
    test_credit_edge();
    test_overflow();
    test_orphan_body();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_out_port.md
NOC_OUT_PORT -- requirements
Module: noc_out_port

Parameters
REQ-001 NUM_IN, default 5, number of competing input ports (N, S, E, W, L order; index 0 = N).
REQ-002 FLIT_W, default 16, flit width in bits; bits [FLIT_W-1:FLIT_W-2] are flit type.
REQ-003 BUF_DEPTH, default 4, downstream input-buffer depth, i.e. initial credit count; legal range 1..15.

Interface
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_i  in  NUM_IN  per-input request; flit on flit_i slice is valid.
REQ-008 flit_i  in  NUM_IN*FLIT_W  packed flits, input k at bits [k*FLIT_W +: FLIT_W].
REQ-009 grant_o  out  NUM_IN  one-hot/zero, combinational; input k's flit is consumed this cycle.
REQ-010 valid_o  out  1  registered; flit_o valid toward downstream.
REQ-011 flit_o  out  FLIT_W  registered forwarded flit.
REQ-012 incr_i  in  1  one credit returned by downstream this cycle.
REQ-013 credits_o  out  4  current credit count.
REQ-014 locked_o  out  1  a packet currently owns the port.
REQ-015 err_o  out  1  sticky credit-overflow flag.

Function
REQ-016 Flit types SHALL be 00 single (head+tail), 01 head, 10 body, 11 tail.
REQ-017 FSM states SHALL be IDLE and LOCKED, with an owner register of clog2(NUM_IN) bits.
REQ-018 IDLE: if credits>0 and any req_i, grant the first requesting input in round-robin order starting at (last_winner+1) mod NUM_IN.
REQ-019 IDLE grant of a head flit SHALL move to LOCKED with owner=winner; a single flit SHALL stay IDLE; any grant SHALL set last_winner=winner.
REQ-020 IDLE grant of a body or tail flit SHALL be forwarded, the FSM SHALL stay IDLE, and err_o SHALL be set.
REQ-021 LOCKED: only req_i[owner] SHALL be granted, when credits>0; other requests SHALL be ignored.
REQ-022 LOCKED grant of a tail or single flit SHALL return to IDLE; head/body SHALL stay LOCKED.
REQ-023 A granted flit SHALL appear on flit_o with valid_o=1 exactly one cycle after grant; otherwise valid_o=0 and flit_o SHALL hold its last value.
REQ-024 No grant SHALL be issued when credits==0; the winner is re-evaluated every cycle (no grant memory).
REQ-025 Credits SHALL decrement by 1 per grant and increment by 1 per incr_i; simultaneous grant and incr_i SHALL leave credits unchanged.
REQ-026 incr_i while credits==BUF_DEPTH with no grant SHALL leave credits at BUF_DEPTH and set err_o.
REQ-027 A grant at credits==1 with incr_i in the same cycle SHALL be allowed, and credits SHALL remain 1.
REQ-028 err_o SHALL clear only on rst.
REQ-029 locked_o SHALL equal (state==LOCKED).

Reset
REQ-030 On rst: state=IDLE, owner=0, last_winner=NUM_IN-1 (input 0 has first priority), credits=BUF_DEPTH, valid_o=0, flit_o=0, err_o=0.
REQ-031 grant_o SHALL be 0 while rst is high.
REQ-032 Reset mid-packet SHALL discard the lock and restore full credits; the next cycle SHALL behave as after power-up.

Structure
REQ-033 Package noc_pkg SHALL hold the flit-type enum, FLIT_TYPE_* constants and default FLIT_W/BUF_DEPTH/NUM_IN values.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last_winner; outputs one-hot grant, winner index), purely combinational.
REQ-035 Credit counter, FSM and output register SHALL live in noc_out_port.

Verification
REQ-036 Reset, then req_i=5'b10001 with single flits and incr_i tied to grant -> grants on inputs 0,4,0,4...; flit_o follows one cycle later.
REQ-037 Input 1 sends head,body,body,tail while input 2 requests continuously -> input 2 is first granted the cycle after input 1's tail; locked_o is high from the cycle after the head grant through the cycle of the tail grant.
REQ-038 BUF_DEPTH=4, incr_i=0, input 0 streams single flits -> 4 grants, credits_o reaches 0, then no grants; one incr_i pulse -> exactly one more grant.
REQ-039 credits_o=1, grant and incr_i in the same cycle -> credits_o stays 1 and the next cycle grants again.
REQ-040 incr_i pulse at credits_o=4 -> credits_o stays 4, err_o=1 and remains 1 until rst.
REQ-041 rst asserted mid-packet (after head, before tail) -> locked_o=0, credits_o=4, valid_o=0 immediately; input 0 has priority after release.
